w8r16_pack_fifo: RTL and testbench

//  Single-clock synchronous FIFO, 8-bit write side, 16-bit read side. It is the widening

---
 rtl/w8r16_pack_fifo_if.sv | 31 +++
 rtl/w8r16_pack_fifo.sv | 107 ++++++++++
 tb/tb_w8r16_pack_fifo.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/w8r16_pack_fifo_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | w8r16_pack_fifo_if : byte-write / word-read bus bundle for w8r16_pack_fifo   |
// | Rev 1.0 - initial release                                                    |
// +-----------------------------------------------------------------------------+
interface w8r16_pack_fifo_if #(
  parameter int unsigned DEPTH_W = 9
);
  logic               wr_en;
  logic [7:0]         wr_data;
  logic               flush;
  logic               wr_full;
  logic               almost_full;
  logic               byte_pending;
  logic               rd_en;
  logic [15:0]        rd_data;
  logic               rd_empty;
  logic               almost_empty;
  logic [DEPTH_W:0]   word_cnt;

  modport master (
    output wr_en, wr_data, flush, rd_en,
    input  wr_full, almost_full, byte_pending, rd_data, rd_empty, almost_empty, word_cnt
  );

  modport slave (
    input  wr_en, wr_data, flush, rd_en,
    output wr_full, almost_full, byte_pending, rd_data, rd_empty, almost_empty, word_cnt
  );
endinterface
`default_nettype wire

// File: rtl/w8r16_pack_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | w8r16_pack_fifo : packs byte pairs into 16-bit words, flush pads a lone byte |
// | Rev 1.0 - initial release                                                    |
// +-----------------------------------------------------------------------------+
module w8r16_pack_fifo #(
  parameter int unsigned DEPTH_W          = 9,
  parameter int unsigned ALMOST_FULL_NUM  = 500,
  parameter int unsigned ALMOST_EMPTY_NUM = 4,
  parameter logic [7:0]  PAD_BYTE         = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  w8r16_pack_fifo_if.slave   bus
);

  localparam int unsigned    c_DEPTH_N = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0] c_DEPTH = {1'b1, {DEPTH_W{1'b0}}};
  localparam logic [DEPTH_W:0] c_AF    = ALMOST_FULL_NUM[DEPTH_W:0];
  localparam logic [DEPTH_W:0] c_AE    = ALMOST_EMPTY_NUM[DEPTH_W:0];

  logic [15:0]        mem [c_DEPTH_N];

  logic [DEPTH_W-1:0] wptr_q, wptr_d;
  logic [DEPTH_W-1:0] rptr_q, rptr_d;
  logic [DEPTH_W:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic [7:0]         hold_q, hold_d;
  logic [15:0]        rd_data_q;

  logic               full, empty, wr_acc, rd_acc, commit;
  logic [15:0]        commit_data;

  always_comb begin
    full   = (cnt_q == c_DEPTH);
    empty  = (cnt_q == '0);
    wr_acc = bus.wr_en & ~full;
    rd_acc = bus.rd_en & ~empty;
    // A commit happens on a completing write, a write+flush, or a flush over a held byte.
    commit = ~full & (bus.wr_en ? (pend_q | bus.flush) : (bus.flush & pend_q));

    if (pend_q)
      commit_data = bus.wr_en ? {bus.wr_data, hold_q} : {PAD_BYTE, hold_q};
    else
      commit_data = {PAD_BYTE, bus.wr_data};

    pend_d = pend_q;
    hold_d = hold_q;
    if (wr_acc) begin
      if (!pend_q && !bus.flush) begin
        hold_d = bus.wr_data;
        pend_d = 1'b1;
      end else begin
        pend_d = 1'b0;
      end
    end else if (commit) begin
      pend_d = 1'b0;
    end

    wptr_d = wptr_q + DEPTH_W'(commit);
    rptr_d = rptr_q + DEPTH_W'(rd_acc);
    case ({commit, rd_acc})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      hold_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      hold_q <= hold_d;
    end
  end

  // Storage array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (commit)
      mem[wptr_q] <= commit_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_data_q <= '0;
    else if (rd_acc)
      rd_data_q <= mem[rptr_q];
  end

  assign bus.wr_full      = full;
  assign bus.rd_empty     = empty;
  assign bus.almost_full  = (cnt_q >= c_AF);
  assign bus.almost_empty = (cnt_q <= c_AE);
  assign bus.byte_pending = pend_q;
  assign bus.word_cnt     = cnt_q;
  assign bus.rd_data      = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_w8r16_pack_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_w8r16_pack_fifo : queue-model bench for the 8->16 packing FIFO            |
// | Rev 1.0 - initial release                                                    |
// +-----------------------------------------------------------------------------+
module tb_w8r16_pack_fifo;
  localparam int DW    = 9;
  localparam int DEPTH = 512;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  w8r16_pack_fifo_if #(.DEPTH_W(DW)) bus ();

  w8r16_pack_fifo #(
    .DEPTH_W(DW), .ALMOST_FULL_NUM(500), .ALMOST_EMPTY_NUM(4), .PAD_BYTE(8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of finished words plus a single held byte.
  logic [15:0] mq[$];
  logic        m_pend;
  logic [7:0]  m_hold;
  logic [15:0] m_rd;
  bit          m_full, m_empty;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_pend = 1'b0;
      m_hold = 8'h00;
      m_rd   = 16'h0000;
    end else begin
      m_full  = (mq.size() == DEPTH);
      m_empty = (mq.size() == 0);
      if (bus.rd_en && !m_empty)
        m_rd = mq.pop_front();
      if (!m_full) begin
        if (bus.wr_en) begin
          if (m_pend) begin
            mq.push_back({bus.wr_data, m_hold});
            m_pend = 1'b0;
          end else if (bus.flush) begin
            mq.push_back({8'h00, bus.wr_data});
          end else begin
            m_hold = bus.wr_data;
            m_pend = 1'b1;
          end
        end else if (bus.flush && m_pend) begin
          mq.push_back({8'h00, m_hold});
          m_pend = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("word_cnt",     32'(bus.word_cnt), 32'(mq.size()));
      chk("wr_full",      32'(bus.wr_full),  32'(mq.size() == DEPTH));
      chk("rd_empty",     32'(bus.rd_empty), 32'(mq.size() == 0));
      chk("almost_full",  32'(bus.almost_full),  32'(mq.size() >= 500));
      chk("almost_empty", 32'(bus.almost_empty), 32'(mq.size() <= 4));
      chk("byte_pending", 32'(bus.byte_pending), 32'(m_pend));
      chk("rd_data",      32'(bus.rd_data),  32'(m_rd));
    end
  end

  task automatic step(input logic we, input logic [7:0] wd, input logic fl, input logic re);
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.flush   = fl;
    bus.rd_en   = re;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = mq.size();
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.flush = 1'b0; bus.rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rd_empty", 32'(bus.rd_empty), 32'd1);
    chk("rst_word_cnt", 32'(bus.word_cnt), 32'd0);
    chk("rst_wr_full",  32'(bus.wr_full),  32'd0);
    rst_n  = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // Byte pairs packed low-byte-first
    step(1, 8'h11, 0, 0); step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0); step(1, 8'h44, 0, 0);
    step(0, 8'h00, 0, 1);
    chk("t1_word0", 32'(bus.rd_data), 32'h2211);
    step(0, 8'h00, 0, 1);
    chk("t1_word1", 32'(bus.rd_data), 32'h4433);
    chk("t1_empty", 32'(bus.rd_empty), 32'd1);

    // Flush padding, separate and combined with the write
    step(1, 8'hA5, 0, 0); step(0, 8'h00, 1, 0);
    chk("t2_cnt",  32'(bus.word_cnt), 32'd1);
    chk("t2_pend", 32'(bus.byte_pending), 32'd0);
    step(0, 8'h00, 0, 1);
    chk("t2_pad", 32'(bus.rd_data), 32'h00A5);
    step(1, 8'h5A, 1, 0);
    step(0, 8'h00, 0, 1);
    chk("t2_wrflush", 32'(bus.rd_data), 32'h005A);

    // Fill to full, blocked write, ordered drain
    for (int i = 0; i < 1024; i++) step(1, 8'(i), 0, 0);
    chk("t3_full", 32'(bus.wr_full), 32'd1);
    chk("t3_cnt",  32'(bus.word_cnt), 32'd512);
    step(1, 8'hFF, 0, 0);
    chk("t3_ignored_pend", 32'(bus.byte_pending), 32'd0);
    for (int k = 0; k < 512; k++) begin
      step(0, 8'h00, 0, 1);
      chk("t3_seq", 32'(bus.rd_data), 32'({8'(2*k+1), 8'(2*k)}));
    end
    chk("t3_empty", 32'(bus.rd_empty), 32'd1);

    // Simultaneous read and write at full and at count 10
    for (int i = 0; i < 1024; i++) step(1, 8'($urandom), 0, 0);
    step(1, 8'hC3, 0, 1);
    chk("t4_full_rw_cnt",  32'(bus.word_cnt), 32'd511);
    chk("t4_full_rw_pend", 32'(bus.byte_pending), 32'd0);
    drain();
    repeat (10) step(1, 8'($urandom), 1, 0);
    step(1, 8'h77, 0, 0);
    step(1, 8'h88, 0, 1);
    chk("t4_cnt10", 32'(bus.word_cnt), 32'd10);
    drain();

    // Threshold sweep, pointers already wrapped by earlier traffic
    for (int k = 1; k <= 500; k++) begin
      step(1, 8'(k), 1, 0);
      if (k == 4)   chk("t5_ae_at4",   32'(bus.almost_empty), 32'd1);
      if (k == 5)   chk("t5_ae_at5",   32'(bus.almost_empty), 32'd0);
      if (k == 499) chk("t5_af_at499", 32'(bus.almost_full),  32'd0);
      if (k == 500) chk("t5_af_at500", 32'(bus.almost_full),  32'd1);
    end
    drain();

    // Random traffic against the queue model
    for (int i = 0; i < 4000; i++)
      step(1'($urandom_range(0, 9) < 6), 8'($urandom), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 1)));
    drain();

    // Asynchronous reset mid-operation
    repeat (75) step(1, 8'($urandom), 0, 0);
    step(0, 8'h00, 0, 0);
    chk("t6_cnt37", 32'(bus.word_cnt), 32'd37);
    chk("t6_pend",  32'(bus.byte_pending), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_cnt",   32'(bus.word_cnt), 32'd0);
    chk("t6_rst_pend",  32'(bus.byte_pending), 32'd0);
    chk("t6_rst_rd",    32'(bus.rd_data), 32'd0);
    chk("t6_rst_empty", 32'(bus.rd_empty), 32'd1);
    chk("t6_rst_ae",    32'(bus.almost_empty), 32'd1);
    chk("t6_rst_full",  32'(bus.wr_full), 32'd0);
    chk("t6_rst_af",    32'(bus.almost_full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'hBE, 0, 0); step(1, 8'hEF, 0, 0);
    step(0, 8'h00, 0, 1);
    chk("t6_after_rst", 32'(bus.rd_data), 32'hEFBE);
    step(0, 8'h00, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
